// File: rtl/hls_nchn_in_wait_ctrl.sv
// hls_nchn_in_wait_ctrl
// Joins NUM_CHN valid/ready input channels into a single core transaction.
// A channel's wait starts from the core's chn_iswt0 request (masked while the
// core is stalled) and then stays pending in icwt. Each channel accepts exactly
// one beat per transaction, and that beat is held in dat_q. The transaction
// completes once every requested channel has its beat. A saturating counter
// records the cycles spent waiting.
module hls_nchn_in_wait_ctrl #(
    parameter int NUM_CHN = 2,
    parameter int DW      = 17,
    parameter int CNT_W   = 8
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic                    core_wten,
    input  logic [NUM_CHN-1:0]      chn_iswt0,
    input  logic                    chn_ld_core_psct,
    input  logic [NUM_CHN-1:0]      chn_vd,
    input  logic [NUM_CHN*DW-1:0]   chn_dat,
    output logic [NUM_CHN-1:0]      chn_rdy,
    output logic [NUM_CHN*DW-1:0]   core_dat,
    output logic                    chn_ld_core_sct,
    output logic                    all_got,
    input  logic                    clr_stall,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic [NUM_CHN-1:0] icwt;
    logic [NUM_CHN-1:0] got;
    logic [NUM_CHN-1:0] pdswt0;
    logic [NUM_CHN-1:0] ogwt;
    logic [NUM_CHN-1:0] biwt;
    logic [NUM_CHN-1:0] have;
    logic [DW-1:0]      dat_q [NUM_CHN];
    logic               any_wt;
    logic               complete;

    // A new request only counts when the core is not stalled. A pending wait
    // is OR-merged with any fresh request, so a repeated request is harmless.
    assign pdswt0   = chn_iswt0 & {NUM_CHN{~core_wten}};
    assign ogwt     = pdswt0 | icwt;
    assign any_wt   = |ogwt;

    // Ready depends only on registered state and the request inputs. It never
    // depends on chn_vd, so no combinational loop forms through a producer.
    assign chn_rdy  = ogwt & ~got;
    assign biwt     = chn_rdy & chn_vd;
    assign have     = got | biwt;

    // A channel that is not waiting counts as satisfied.
    assign all_got  = &(~ogwt | have);
    assign complete = all_got & any_wt;

    assign chn_ld_core_sct = chn_ld_core_psct & complete;

    // Present each beat to the core in the same cycle it arrives. Otherwise
    // present the beat captured earlier in this transaction.
    always_comb begin
        core_dat = '0;
        for (int i = 0; i < NUM_CHN; i++) begin
            core_dat[i*DW +: DW] = biwt[i] ? chn_dat[i*DW +: DW] : dat_q[i];
        end
    end

    // Pending and captured flags. Completion clears them all for the next
    // transaction. Otherwise they accumulate.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            icwt <= '0;
            got  <= '0;
        end else if (complete) begin
            icwt <= '0;
            got  <= '0;
        end else begin
            icwt <= ogwt;
            got  <= got | biwt;
        end
    end

    // Capture one beat per channel. The register stays valid until the next
    // transaction overwrites it.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < NUM_CHN; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHN; i++) begin
                if (biwt[i]) begin
                    dat_q[i] <= chn_dat[i*DW +: DW];
                end
            end
        end
    end

    // Count cycles spent waiting without completing. The count saturates at
    // its maximum, and a clear takes priority over counting.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt <= '0;
        end else if (clr_stall) begin
            stall_cnt <= '0;
        end else if (any_wt && !complete && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hls_nchn_in_wait_ctrl.sv
// tb_hls_nchn_in_wait_ctrl
// Directed bench for the multi-channel wait controller. dut is the default
// 2-channel, 8-bit-count configuration. dut4 shares the same inputs but has a
// 4-bit stall counter, and only its stall_cnt is compared.
module tb_hls_nchn_in_wait_ctrl;

    localparam int NUM_CHN = 2;
    localparam int DW      = 17;

    logic                  nvdla_core_clk;
    logic                  nvdla_core_rstn;
    logic                  core_wten;
    logic [NUM_CHN-1:0]    chn_iswt0;
    logic                  chn_ld_core_psct;
    logic [NUM_CHN-1:0]    chn_vd;
    logic [NUM_CHN*DW-1:0] chn_dat;
    logic                  clr_stall;

    logic [NUM_CHN-1:0]    chn_rdy;
    logic [NUM_CHN*DW-1:0] core_dat;
    logic                  chn_ld_core_sct;
    logic                  all_got;
    logic [7:0]            stall_cnt;

    logic [NUM_CHN-1:0]    chn_rdy4;
    logic [NUM_CHN*DW-1:0] core_dat4;
    logic                  sct4;
    logic                  all_got4;
    logic [3:0]            stall_cnt4;

    int checks = 0;
    int errors = 0;

    hls_nchn_in_wait_ctrl #(.NUM_CHN(NUM_CHN), .DW(DW), .CNT_W(8)) dut (
        .nvdla_core_clk   (nvdla_core_clk),
        .nvdla_core_rstn  (nvdla_core_rstn),
        .core_wten        (core_wten),
        .chn_iswt0        (chn_iswt0),
        .chn_ld_core_psct (chn_ld_core_psct),
        .chn_vd           (chn_vd),
        .chn_dat          (chn_dat),
        .chn_rdy          (chn_rdy),
        .core_dat         (core_dat),
        .chn_ld_core_sct  (chn_ld_core_sct),
        .all_got          (all_got),
        .clr_stall        (clr_stall),
        .stall_cnt        (stall_cnt)
    );

    hls_nchn_in_wait_ctrl #(.NUM_CHN(NUM_CHN), .DW(DW), .CNT_W(4)) dut4 (
        .nvdla_core_clk   (nvdla_core_clk),
        .nvdla_core_rstn  (nvdla_core_rstn),
        .core_wten        (core_wten),
        .chn_iswt0        (chn_iswt0),
        .chn_ld_core_psct (chn_ld_core_psct),
        .chn_vd           (chn_vd),
        .chn_dat          (chn_dat),
        .chn_rdy          (chn_rdy4),
        .core_dat         (core_dat4),
        .chn_ld_core_sct  (sct4),
        .all_got          (all_got4),
        .clr_stall        (clr_stall),
        .stall_cnt        (stall_cnt4)
    );

    // 10-time-unit clock; rising edges at 5, 15, 25, ...
    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    typedef struct {
        logic [1:0]  iswt;
        logic        wten;
        logic [1:0]  vd;
        logic [16:0] d0;
        logic [16:0] d1;
        logic        psct;
        logic [1:0]  exp_rdy;
        logic        exp_sct;
        logic        chk_ag;
        logic        exp_ag;
        logic [33:0] exp_dat;
        logic [7:0]  exp_stall;
    } vec_t;

    vec_t vecs [7];

    task automatic applyStimulus(input logic [1:0] iswt, input logic wten,
                                 input logic [1:0] vd, input logic [16:0] d0,
                                 input logic [16:0] d1, input logic psct,
                                 input logic clr);
        chn_iswt0        = iswt;
        core_wten        = wten;
        chn_vd           = vd;
        chn_dat          = {d1, d0};
        chn_ld_core_psct = psct;
        clr_stall        = clr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic pulseReset();
        nvdla_core_rstn = 1'b0;
        #1;
        nvdla_core_rstn = 1'b1;
    endtask

    // Safety net: the bench never waits on a DUT event, but bound it anyway.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected finish before 100000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset state, with no request
        nvdla_core_rstn = 1'b0;
        applyStimulus(2'b00, 1'b0, 2'b00, 17'h0, 17'h0, 1'b0, 1'b0);
        @(posedge nvdla_core_clk);
        #1;
        checkOutput("reset_rdy",   chn_rdy,         0);
        checkOutput("reset_sct",   chn_ld_core_sct, 0);
        checkOutput("reset_dat",   core_dat,        0);
        checkOutput("reset_stall", stall_cnt,       0);
        nvdla_core_rstn = 1'b1;
        tick();

        // Single-cycle vectors, each applied from a freshly reset state
        vecs[0] = '{2'b11, 1'b0, 2'b11, 17'h05555, 17'h1AAAA, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, {17'h1AAAA, 17'h05555}, 8'd0};
        vecs[1] = '{2'b11, 1'b0, 2'b01, 17'h00123, 17'h1FFFF, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, {17'h00000, 17'h00123}, 8'd1};
        vecs[2] = '{2'b10, 1'b0, 2'b11, 17'h0F0F0, 17'h1AAAA, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, {17'h1AAAA, 17'h00000}, 8'd0};
        vecs[3] = '{2'b11, 1'b1, 2'b11, 17'h11111, 17'h02222, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, {17'h00000, 17'h00000}, 8'd0};
        vecs[4] = '{2'b01, 1'b0, 2'b00, 17'h13579, 17'h02468, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, {17'h00000, 17'h00000}, 8'd1};
        vecs[5] = '{2'b11, 1'b0, 2'b11, 17'h1C3C3, 17'h00F0F, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, {17'h00F0F, 17'h1C3C3}, 8'd0};
        vecs[6] = '{2'b00, 1'b0, 2'b11, 17'h1ABCD, 17'h0DCBA, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, {17'h00000, 17'h00000}, 8'd0};

        for (int v = 0; v < 7; v++) begin
            pulseReset();
            applyStimulus(vecs[v].iswt, vecs[v].wten, vecs[v].vd, vecs[v].d0,
                          vecs[v].d1, vecs[v].psct, 1'b0);
            checkOutput($sformatf("vec%0d_rdy", v), chn_rdy, vecs[v].exp_rdy);
            checkOutput($sformatf("vec%0d_sct", v), chn_ld_core_sct, vecs[v].exp_sct);
            if (vecs[v].chk_ag)
                checkOutput($sformatf("vec%0d_all_got", v), all_got, vecs[v].exp_ag);
            checkOutput($sformatf("vec%0d_dat", v), core_dat, vecs[v].exp_dat);
            tick();
            checkOutput($sformatf("vec%0d_stall", v), stall_cnt, vecs[v].exp_stall);
        end

        // Staggered arrival: ch0 at cycle 0, ch1 at cycle 3, with a merged re-request
        pulseReset();
        applyStimulus(2'b11, 1'b0, 2'b01, 17'h12345, 17'h00000, 1'b1, 1'b0);
        checkOutput("stag_c0_rdy", chn_rdy, 2'b11);
        checkOutput("stag_c0_sct", chn_ld_core_sct, 0);
        tick();
        applyStimulus(2'b00, 1'b0, 2'b01, 17'h0AAAA, 17'h00000, 1'b1, 1'b0);
        checkOutput("stag_c1_rdy", chn_rdy, 2'b10);
        checkOutput("stag_c1_dat", core_dat, {17'h00000, 17'h12345});
        checkOutput("stag_c1_sct", chn_ld_core_sct, 0);
        tick();
        applyStimulus(2'b11, 1'b0, 2'b00, 17'h0AAAA, 17'h00000, 1'b1, 1'b0);
        checkOutput("stag_c2_rdy", chn_rdy, 2'b10);
        checkOutput("stag_c2_sct", chn_ld_core_sct, 0);
        tick();
        applyStimulus(2'b00, 1'b0, 2'b10, 17'h0AAAA, 17'h1F0F0, 1'b1, 1'b0);
        checkOutput("stag_c3_rdy", chn_rdy, 2'b10);
        checkOutput("stag_c3_sct", chn_ld_core_sct, 1);
        checkOutput("stag_c3_dat", core_dat, {17'h1F0F0, 17'h12345});
        tick();
        applyStimulus(2'b00, 1'b0, 2'b11, 17'h0AAAA, 17'h1F0F0, 1'b1, 1'b0);
        checkOutput("stag_after_stall", stall_cnt, 3);
        checkOutput("stag_after_rdy", chn_rdy, 2'b00);
        checkOutput("stag_after_sct", chn_ld_core_sct, 0);

        // core_wten gating: the request is masked for 4 cycles, then starts
        pulseReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'b01, 1'b1, 2'b01, 17'h0BEEF, 17'h00000, 1'b1, 1'b0);
            checkOutput($sformatf("wten_c%0d_rdy", c), chn_rdy, 2'b00);
            checkOutput($sformatf("wten_c%0d_sct", c), chn_ld_core_sct, 0);
            tick();
        end
        checkOutput("wten_stall", stall_cnt, 0);
        applyStimulus(2'b01, 1'b0, 2'b01, 17'h0BEEF, 17'h00000, 1'b1, 1'b0);
        checkOutput("wten_go_rdy", chn_rdy, 2'b01);
        checkOutput("wten_go_sct", chn_ld_core_sct, 1);
        checkOutput("wten_go_dat", core_dat, {17'h00000, 17'h0BEEF});
        tick();
        checkOutput("wten_go_stall", stall_cnt, 0);

        // Saturation and clear: 20 stalled cycles
        pulseReset();
        applyStimulus(2'b01, 1'b0, 2'b00, 17'h0, 17'h0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) tick();
        checkOutput("sat_cnt4", stall_cnt4, 15);
        checkOutput("sat_cnt8", stall_cnt, 20);
        applyStimulus(2'b01, 1'b0, 2'b00, 17'h0, 17'h0, 1'b0, 1'b1);
        tick();
        checkOutput("clr_cnt4", stall_cnt4, 0);
        checkOutput("clr_cnt8", stall_cnt, 0);
        applyStimulus(2'b01, 1'b0, 2'b00, 17'h0, 17'h0, 1'b0, 1'b0);
        tick();
        checkOutput("clr_resume_cnt8", stall_cnt, 1);

        // Reset mid-transaction: ch0 captured, ch1 pending
        pulseReset();
        applyStimulus(2'b11, 1'b0, 2'b01, 17'h1BEEF, 17'h00000, 1'b1, 1'b0);
        tick();
        applyStimulus(2'b00, 1'b0, 2'b00, 17'h00000, 17'h00000, 1'b1, 1'b0);
        checkOutput("rmid_pre_rdy", chn_rdy, 2'b10);
        checkOutput("rmid_pre_dat", core_dat, {17'h00000, 17'h1BEEF});
        nvdla_core_rstn = 1'b0;
        #1;
        checkOutput("rmid_in_rdy", chn_rdy, 2'b00);
        checkOutput("rmid_in_dat", core_dat, 0);
        checkOutput("rmid_in_stall", stall_cnt, 0);
        nvdla_core_rstn = 1'b1;
        tick();
        applyStimulus(2'b00, 1'b0, 2'b10, 17'h00000, 17'h1CAFE, 1'b1, 1'b0);
        checkOutput("rmid_post_rdy", chn_rdy, 2'b00);
        checkOutput("rmid_post_sct", chn_ld_core_sct, 0);
        tick();
        checkOutput("rmid_post2_sct", chn_ld_core_sct, 0);
        checkOutput("rmid_post2_dat", core_dat, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
